shift_add_multiplier: RTL and testbench

//   Sequential unsigned 4x4 multiplier using the shift-and-add method.

---
 rtl/shift_add_multiplier_if.sv | 30 +++
 rtl/shift_add_multiplier.sv | 133 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bus of the shift-and-add multiplier.
// The master issues start with operands; the slave reports ready, done and product.
interface shift_add_multiplier_if #(
   parameter int unsigned WIDTH = 4
);
   logic                   start;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   ready;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start,
      output a,
      output b,
      input  ready,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output ready,
      output done,
      output product
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 4x4 shift-and-add multiplier built around one 4-bit
// ripple adder; one add-and-shift step per RUN cycle, 8-bit product.

module four_bit_adder (
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   input  logic       carry_in_i,
   output logic [3:0] sum_o,
   output logic       carry_out_o
);
   // Ripple-carry chain of full adders
   always_comb begin
      logic carry;
      carry = carry_in_i;
      sum_o = 4'd0;
      for (int i = 0; i < 4; i++) begin
         sum_o[i] = x_i[i] ^ y_i[i] ^ carry;
         carry    = (x_i[i] & y_i[i]) | (carry & (x_i[i] ^ y_i[i]));
      end
      carry_out_o = carry;
   end
endmodule

module shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   shift_add_multiplier_if.slave bus
);
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned PROD_W    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e              state_q,   state_d;
   logic [WIDTH-1:0]    m_q,       m_d;
   logic [WIDTH-1:0]    acc_q,     acc_d;
   logic [WIDTH-1:0]    q_q,       q_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic                ready_q,   ready_d;
   logic                done_q,    done_d;
   logic [PROD_W-1:0]   product_q, product_d;

   logic [WIDTH-1:0]    addend;
   logic [WIDTH-1:0]    sum;
   logic                carry_out;

   assign addend = q_q[0] ? m_q : '0;

   four_bit_adder u_adder (
      .x_i         (acc_q),
      .y_i         (addend),
      .carry_in_i  (1'b0),
      .sum_o       (sum),
      .carry_out_o (carry_out)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      count_d   = count_q;
      product_d = product_q;
      ready_d   = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               m_d     = bus.a;
               q_d     = bus.b;
               acc_d   = '0;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Carry-out shifts into the ACC msb, so the top carry bit is never lost
            acc_d   = {carry_out, sum[WIDTH-1:1]};
            q_d     = {sum[0], q_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ITER) begin
               state_d   = S_DONE;
               product_d = {acc_d, q_d};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   assign bus.ready   = ready_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: a cycle-level protocol model
// pushes a*b on every acceptance, a monitor pops and compares on done.
module tb_shift_add_multiplier;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   logic [7:0] held     = 8'd0;
   int         busy     = 0;
   bit         armed    = 1'b0;
   bit         rst_pend = 1'b0;

   shift_add_multiplier_if #(.WIDTH(4)) bus_if ();

   shift_add_multiplier #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: busy counts the negedges until the unit is idle again.
   // Accept at edge E0 -> ready low for 5 sampled cycles, done on the 5th.
   always @(negedge clk) begin
      if (rst_pend) begin
         sb.delete();
         held     = 8'd0;
         busy     = 0;
         armed    = 1'b1;
         rst_pend = 1'b0;
      end
      if (armed) begin
         check("ready", 32'(bus_if.ready), 32'(busy == 0));
         check("done",  32'(bus_if.done),  32'(busy == 1));
      end
      if (!rst_n) begin
         rst_pend = 1'b1;
      end else if (armed) begin
         if (busy != 0) begin
            busy--;
         end else if (bus_if.start) begin
            sb.push_back(8'(int'(bus_if.a) * int'(bus_if.b)));
            busy = 5;
         end
      end
   end

   // Result monitor
   always @(negedge clk) begin
      #1;
      if (armed) begin
         if (bus_if.done === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_without_op: got done=1 expected no pending op at %0t", $time);
            end else begin
               held = sb.pop_front();
               check("product", 32'(bus_if.product), 32'(held));
            end
         end else begin
            check("product_hold", 32'(bus_if.product), 32'(held));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Present operands with start; returns 2 time units after the accepting edge
   task automatic issue(input logic [3:0] av, input logic [3:0] bv);
      int n;
      n = 0;
      bus_if.start = 1'b1;
      bus_if.a     = av;
      bus_if.b     = bv;
      do begin
         @(negedge clk);
         n++;
      end while (bus_if.ready !== 1'b1 && n < 50);
      if (bus_if.ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got ready=%b expected 1 within 50 cycles", bus_if.ready);
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus_if.start = 1'b0;
      bus_if.a     = 4'd0;
      bus_if.b     = 4'd0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);

      // Directed products, including all-ones and zero operands
      issue(4'h3, 4'h5); bus_if.start = 1'b0; cyc(6);
      issue(4'hF, 4'hF); bus_if.start = 1'b0; cyc(6);
      issue(4'hD, 4'hB); bus_if.start = 1'b0; cyc(6);
      issue(4'h0, 4'h9); bus_if.start = 1'b0; cyc(6);
      issue(4'h9, 4'h0); bus_if.start = 1'b0; cyc(6);

      // start held and operands changed while busy
      issue(4'h7, 4'h6);
      bus_if.a = 4'h1;
      bus_if.b = 4'h1;
      cyc(3);
      bus_if.start = 1'b0;
      cyc(6);

      // Reset during the second RUN cycle
      issue(4'hF, 4'hF);
      bus_if.start = 1'b0;
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(8);

      // Back-to-back with start permanently high
      issue(4'h7, 4'h6);
      bus_if.a = 4'hD;
      bus_if.b = 4'hB;
      cyc(6);
      bus_if.a = 4'($urandom);
      bus_if.b = 4'($urandom);
      cyc(6);
      bus_if.start = 1'b0;
      cyc(8);

      // Random operands, gaps and junk on the bus while busy
      for (int i = 0; i < 40; i++) begin
         cyc($urandom_range(0, 3));
         issue(4'($urandom), 4'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 5; k++) begin
               bus_if.start = 1'($urandom);
               bus_if.a     = 4'($urandom);
               bus_if.b     = 4'($urandom);
               cyc(1);
            end
         end
         bus_if.start = 1'b0;
      end

      // Drain outstanding operations
      for (int n = 0; n < 30 && (busy != 0 || sb.size() != 0); n++) begin
         cyc(1);
      end
      check("drain", 32'(sb.size()), 32'd0);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
